// File: rtl/pc_gen_pkg.sv
// Shared constants for the IF-stage program-counter generator:
// default CPU width, pending-redirect source encoding and FSM state encoding.
package pc_gen_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [1:0] PEND_NONE  = 2'd0;
    localparam logic [1:0] PEND_FLUSH = 2'd1;
    localparam logic [1:0] PEND_TRAP  = 2'd2;

    localparam logic ST_BOOT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a trap/flush redirect that arrives while the fetch request is stalled,
// and resolves the redirect half of the next-PC priority (trap > flush, live > pending).
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  hold,
    input  logic                  trap_valid,
    input  logic [ADDR_WIDTH-1:0] trap_pc,
    input  logic                  flush_valid,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  redir_valid,
    output logic [ADDR_WIDTH-1:0] redir_pc,
    output logic                  pending_valid
);

    logic [1:0]            pend_src;
    logic [ADDR_WIDTH-1:0] pend_pc;

    // A trap always overwrites; a flush may only replace a flush or an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_src <= PEND_NONE;
            pend_pc  <= '0;
        end else if (run && hold) begin
            if (trap_valid) begin
                pend_src <= PEND_TRAP;
                pend_pc  <= trap_pc;
            end else if (flush_valid && (pend_src != PEND_TRAP)) begin
                pend_src <= PEND_FLUSH;
                pend_pc  <= flush_pc;
            end
        end else begin
            pend_src <= PEND_NONE;
        end
    end

    assign pending_valid = (pend_src != PEND_NONE);

    always_comb begin
        redir_valid = 1'b1;
        redir_pc    = pend_pc;
        if (trap_valid) begin
            redir_pc = trap_pc;
        end else if (pend_src == PEND_TRAP) begin
            redir_pc = pend_pc;
        end else if (flush_valid) begin
            redir_pc = flush_pc;
        end else if (pend_src == PEND_FLUSH) begin
            redir_pc = pend_pc;
        end else begin
            redir_valid = 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: boot delay, fixed-priority next-PC
// selection and a valid/ready fetch request that stays stable while stalled.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_WIDTH,
    parameter int INST_BYTES = 4,
    parameter int BOOT_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rst_pc,
    input  logic                  pipeline_stall,
    input  logic                  trap_valid,
    input  logic [ADDR_WIDTH-1:0] trap_pc,
    input  logic                  flush_valid,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  pred_valid,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic                  fetch_ready,
    output logic                  ena,
    output logic                  fetch_valid,
    output logic [ADDR_WIDTH-1:0] curr_pc_o,
    output logic                  redirect_pending_o
);

    localparam int                    CNT_W      = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(BOOT_DELAY - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INST_BYTES - 1));
    localparam logic [ADDR_WIDTH-1:0] INST_STEP  = ADDR_WIDTH'(INST_BYTES);

    logic                  state;
    logic [CNT_W-1:0]      boot_cnt;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  run;
    logic                  hold;
    logic                  redir_valid;
    logic [ADDR_WIDTH-1:0] redir_pc;

    assign run         = (state == ST_RUN);
    assign ena         = run;
    assign fetch_valid = run;
    assign hold        = fetch_valid & ~fetch_ready;

    // Outside RUN the reset vector is shown directly, so an async reset
    // presents rst_pc immediately without an async data load.
    assign curr_pc_o = run ? pc_q : (rst_pc & ALIGN_MASK);

    pc_redirect_buf #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_redirect_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .hold         (hold),
        .trap_valid   (trap_valid),
        .trap_pc      (trap_pc & ALIGN_MASK),
        .flush_valid  (flush_valid),
        .flush_pc     (flush_pc & ALIGN_MASK),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .pending_valid(redirect_pending_o)
    );

    // Redirects beat the stall; prediction and sequential advance respect it.
    always_comb begin
        next_pc = pc_q;
        if (redir_valid) begin
            next_pc = redir_pc;
        end else if (pred_valid && !pipeline_stall) begin
            next_pc = pred_pc & ALIGN_MASK;
        end else if (!pipeline_stall) begin
            next_pc = pc_q + INST_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
            pc_q     <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    pc_q <= rst_pc & ALIGN_MASK;
                    if (boot_cnt == CNT_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        boot_cnt <= boot_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!hold) begin
                        pc_q <= next_pc;
                    end
                end
            endcase
        end
    end

endmodule
